mips_encode_seq: RTL and testbench

Sequential MIPS instruction encoder: the inverse of the team's mips_decode. It accepts one symbolic instruction per handshake (mnemonic code plus register/immediate/target fields) and emits 32-bit machine words on a valid/ready stream. It expands pseudo-instructions `li`, `move` and `nop` into one or two real words. It feeds the instruction-memory loader and decoder test benches.

---
 rtl/mips_encode_seq.sv | 175 +++++++++++++++++
 tb/tb_mips_encode_seq.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_encode_seq.sv
// Sequential MIPS encoder: symbolic instruction in, 32-bit words out.
// Expands li/move/nop pseudo-ops into one or two real machine words.
module mips_encode_seq #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4:0]           in_op,
  input  logic [4:0]           in_rs,
  input  logic [4:0]           in_rt,
  input  logic [4:0]           in_rd,
  input  logic [31:0]          in_imm,
  input  logic [25:0]          in_target,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_instr,
  output logic                 out_last,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OUT  = 2'd1,
    OUT2 = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [31:0]          instr_q, instr_d;
  logic                 last_q, last_d;
  logic                 err_q, err_d;
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]           rt_q, rt_d;
  logic [15:0]          lo_q, lo_d;

  logic [31:0] enc_word;
  logic        enc_two;
  logic        enc_unk;
  logic        accept;

  function automatic logic [31:0] r_type(
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic [4:0] rd,
    input logic [5:0] funct
  );
    return {6'h00, rs, rt, rd, 5'd0, funct};
  endfunction

  function automatic logic [31:0] i_type(
    input logic [5:0]  op,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [15:0] imm
  );
    return {op, rs, rt, imm};
  endfunction

  always_comb begin
    enc_word = 32'h0;
    enc_two  = 1'b0;
    enc_unk  = 1'b0;
    unique case (in_op)
      5'd0:  enc_word = r_type(in_rs, in_rt, in_rd, 6'h20);
      5'd1:  enc_word = r_type(in_rs, in_rt, in_rd, 6'h21);
      5'd2:  enc_word = r_type(in_rs, in_rt, in_rd, 6'h22);
      5'd3:  enc_word = r_type(in_rs, in_rt, in_rd, 6'h24);
      5'd4:  enc_word = r_type(in_rs, in_rt, in_rd, 6'h25);
      5'd5:  enc_word = r_type(in_rs, in_rt, in_rd, 6'h26);
      5'd6:  enc_word = r_type(in_rs, in_rt, in_rd, 6'h27);
      5'd7:  enc_word = r_type(in_rs, in_rt, in_rd, 6'h2a);
      5'd8:  enc_word = {6'h00, in_rs, 15'd0, 6'h08};
      5'd9:  enc_word = i_type(6'h08, in_rs, in_rt, in_imm[15:0]);
      5'd10: enc_word = i_type(6'h09, in_rs, in_rt, in_imm[15:0]);
      5'd11: enc_word = i_type(6'h0c, in_rs, in_rt, in_imm[15:0]);
      5'd12: enc_word = i_type(6'h0d, in_rs, in_rt, in_imm[15:0]);
      5'd13: enc_word = i_type(6'h0e, in_rs, in_rt, in_imm[15:0]);
      5'd14: enc_word = i_type(6'h0f, 5'd0, in_rt, in_imm[15:0]);
      5'd15: enc_word = i_type(6'h23, in_rs, in_rt, in_imm[15:0]);
      5'd16: enc_word = i_type(6'h24, in_rs, in_rt, in_imm[15:0]);
      5'd17: enc_word = i_type(6'h2b, in_rs, in_rt, in_imm[15:0]);
      5'd18: enc_word = i_type(6'h28, in_rs, in_rt, in_imm[15:0]);
      5'd19: enc_word = i_type(6'h04, in_rs, in_rt, in_imm[15:0]);
      5'd20: enc_word = i_type(6'h05, in_rs, in_rt, in_imm[15:0]);
      5'd21: enc_word = {6'h02, in_target};
      5'd22: begin
        // Upper half zero: a single ori from $0 suffices.
        if (in_imm[31:16] == 16'h0) begin
          enc_word = i_type(6'h0d, 5'd0, in_rt, in_imm[15:0]);
        end else begin
          enc_word = i_type(6'h0f, 5'd0, in_rt, in_imm[31:16]);
          enc_two  = (in_imm[15:0] != 16'h0);
        end
      end
      5'd23: enc_word = r_type(in_rs, 5'd0, in_rd, 6'h21);
      5'd24: enc_word = 32'h0;
      default: enc_unk = 1'b1;
    endcase
  end

  assign in_ready  = (state_q == IDLE) |
                     ((state_q == OUT) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q != IDLE);
  assign out_instr = instr_q;
  assign out_last  = last_q;
  assign err       = err_q;
  assign err_count = cnt_q;

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    last_d  = last_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    rt_d    = rt_q;
    lo_d    = lo_q;
    unique case (state_q)
      IDLE, OUT: begin
        if (accept) begin
          if (enc_unk) begin
            err_d   = 1'b1;
            state_d = IDLE;
            if (cnt_q != {ERR_CNT_W{1'b1}}) begin
              cnt_d = cnt_q + ERR_CNT_W'(1);
            end
          end else if (enc_two) begin
            state_d = OUT2;
            instr_d = enc_word;
            last_d  = 1'b0;
            rt_d    = in_rt;
            lo_d    = in_imm[15:0];
          end else begin
            state_d = OUT;
            instr_d = enc_word;
            last_d  = 1'b1;
          end
        end else if ((state_q == OUT) && out_ready) begin
          state_d = IDLE;
        end
      end
      OUT2: begin
        if (out_ready) begin
          state_d = OUT;
          instr_d = i_type(6'h0d, rt_q, rt_q, lo_q);
          last_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      instr_q <= 32'h0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      rt_q    <= 5'd0;
      lo_q    <= 16'h0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      last_q  <= last_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      rt_q    <= rt_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: tb/tb_mips_encode_seq.sv
// Directed bench for mips_encode_seq.
// Each scenario task drives vectors and checks hand-computed words.
module tb_mips_encode_seq;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_op;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [31:0] in_imm;
  logic [25:0] in_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_last;
  logic        err;
  logic [7:0]  err_count;

  int total;
  int bad;

  mips_encode_seq #(.ERR_CNT_W(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_rs     (in_rs),
    .in_rt     (in_rt),
    .in_rd     (in_rd),
    .in_imm    (in_imm),
    .in_target (in_target),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_last  (out_last),
    .err       (err),
    .err_count (err_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_in(
    input logic [4:0]  op,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [31:0] imm,
    input logic [25:0] tgt
  );
    in_valid  = 1'b1;
    in_op     = op;
    in_rs     = rs;
    in_rt     = rt;
    in_rd     = rd;
    in_imm    = imm;
    in_target = tgt;
  endtask

  task automatic clear_in();
    in_valid  = 1'b0;
    in_op     = 5'd0;
    in_rs     = 5'd0;
    in_rt     = 5'd0;
    in_rd     = 5'd0;
    in_imm    = 32'h0;
    in_target = 26'h0;
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    out_ready = 1'b0;
    clear_in();
    step();
    step();
    total++;
    if (out_valid !== 1'b0 || out_instr !== 32'h0 ||
        out_last !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL reset_outs: got v=%b i=%h l=%b e=%b want 0",
               out_valid, out_instr, out_last, err);
    end
    total++;
    if (err_count !== 8'd0) begin
      bad++;
      $display("FAIL reset_cnt: got %0d want 0", err_count);
    end
    reset = 1'b1;
    step();
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL idle_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    set_in(5'd0, 5'd1, 5'd2, 5'd3, 32'h0, 26'h0);
    step();
    total++;
    if (out_valid !== 1'b1 || out_instr !== 32'h00221820 ||
        out_last !== 1'b1) begin
      bad++;
      $display("FAIL add: got v=%b i=%h l=%b want 1 00221820 1",
               out_valid, out_instr, out_last);
    end
    set_in(5'd17, 5'd29, 5'd2, 5'd0, 32'h4, 26'h0);
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b_ready: got %b want 1", in_ready);
    end
    step();
    total++;
    if (out_valid !== 1'b1 || out_instr !== 32'hAFA20004 ||
        out_last !== 1'b1) begin
      bad++;
      $display("FAIL sw: got v=%b i=%h l=%b want 1 afa20004 1",
               out_valid, out_instr, out_last);
    end
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL sw_err: got %b want 0", err);
    end
    clear_in();
    step();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL drain: got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_li_two();
    out_ready = 1'b0;
    set_in(5'd22, 5'd0, 5'd9, 5'd0, 32'h12345678, 26'h0);
    step();
    clear_in();
    for (int c = 0; c < 4; c++) begin
      if (c == 3) out_ready = 1'b1;
      total++;
      if (out_valid !== 1'b1 || out_instr !== 32'h3C091234 ||
          out_last !== 1'b0) begin
        bad++;
        $display("FAIL li_lui c%0d: got v=%b i=%h l=%b want 1 3c091234 0",
                 c, out_valid, out_instr, out_last);
      end
      total++;
      if (in_ready !== 1'b0) begin
        bad++;
        $display("FAIL li_ready c%0d: got %b want 0", c, in_ready);
      end
      if (c < 3) step();
    end
    step();
    total++;
    if (out_valid !== 1'b1 || out_instr !== 32'h35295678 ||
        out_last !== 1'b1) begin
      bad++;
      $display("FAIL li_ori: got v=%b i=%h l=%b want 1 35295678 1",
               out_valid, out_instr, out_last);
    end
    step();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL li_drain: got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_li_single();
    out_ready = 1'b1;
    set_in(5'd22, 5'd0, 5'd9, 5'd0, 32'h000000FF, 26'h0);
    step();
    clear_in();
    total++;
    if (out_valid !== 1'b1 || out_instr !== 32'h340900FF ||
        out_last !== 1'b1) begin
      bad++;
      $display("FAIL li_lo: got v=%b i=%h l=%b want 1 340900ff 1",
               out_valid, out_instr, out_last);
    end
    step();
    set_in(5'd22, 5'd0, 5'd9, 5'd0, 32'hABCD0000, 26'h0);
    step();
    clear_in();
    total++;
    if (out_valid !== 1'b1 || out_instr !== 32'h3C09ABCD ||
        out_last !== 1'b1) begin
      bad++;
      $display("FAIL li_hi: got v=%b i=%h l=%b want 1 3c09abcd 1",
               out_valid, out_instr, out_last);
    end
    step();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL li_hi_extra: got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_misc_ops();
    logic [4:0]  ops [5];
    logic [4:0]  rss [5];
    logic [4:0]  rts [5];
    logic [4:0]  rds [5];
    logic [31:0] imms [5];
    logic [25:0] tgts [5];
    logic [31:0] exps [5];
    ops[0] = 5'd21; rss[0] = 5'd0;  rts[0] = 5'd0; rds[0] = 5'd0;
    imms[0] = 32'h0; tgts[0] = 26'h0100000; exps[0] = 32'h08100000;
    ops[1] = 5'd8;  rss[1] = 5'd31; rts[1] = 5'd7; rds[1] = 5'd6;
    imms[1] = 32'h0; tgts[1] = 26'h0; exps[1] = 32'h03E00008;
    ops[2] = 5'd19; rss[2] = 5'd4;  rts[2] = 5'd5; rds[2] = 5'd0;
    imms[2] = 32'hFFFE; tgts[2] = 26'h0; exps[2] = 32'h1085FFFE;
    ops[3] = 5'd23; rss[3] = 5'd5;  rts[3] = 5'd9; rds[3] = 5'd4;
    imms[3] = 32'h0; tgts[3] = 26'h0; exps[3] = 32'h00A02021;
    ops[4] = 5'd24; rss[4] = 5'd3;  rts[4] = 5'd3; rds[4] = 5'd3;
    imms[4] = 32'h1234; tgts[4] = 26'h0; exps[4] = 32'h00000000;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      set_in(ops[k], rss[k], rts[k], rds[k], imms[k], tgts[k]);
      step();
      clear_in();
      total++;
      if (out_valid !== 1'b1 || out_instr !== exps[k] ||
          out_last !== 1'b1) begin
        bad++;
        $display("FAIL op%0d: got v=%b i=%h l=%b want 1 %h 1",
                 ops[k], out_valid, out_instr, out_last, exps[k]);
      end
      step();
    end
  endtask

  task automatic test_unknown();
    int exp_cnt;
    out_ready = 1'b1;
    set_in(5'd31, 5'd1, 5'd1, 5'd1, 32'h0, 26'h0);
    for (int n = 0; n < 300; n++) begin
      step();
      exp_cnt = (n + 1 > 255) ? 255 : n + 1;
      total++;
      if (out_valid !== 1'b0 || err !== 1'b1) begin
        bad++;
        $display("FAIL unk n%0d: got v=%b e=%b want 0 1",
                 n, out_valid, err);
      end
      total++;
      if (err_count !== exp_cnt[7:0]) begin
        bad++;
        $display("FAIL unk_cnt n%0d: got %0d want %0d",
                 n, err_count, exp_cnt);
      end
    end
    clear_in();
    step();
    total++;
    if (err !== 1'b0 || err_count !== 8'd255) begin
      bad++;
      $display("FAIL unk_end: got e=%b c=%0d want 0 255", err, err_count);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    set_in(5'd22, 5'd0, 5'd9, 5'd0, 32'h12345678, 26'h0);
    step();
    clear_in();
    total++;
    if (out_instr !== 32'h3C091234 || out_last !== 1'b0) begin
      bad++;
      $display("FAIL mid_lui: got i=%h l=%b want 3c091234 0",
               out_instr, out_last);
    end
    reset = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || err_count !== 8'd0) begin
      bad++;
      $display("FAIL mid_reset: got v=%b c=%0d want 0 0",
               out_valid, err_count);
    end
    step();
    reset     = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL mid_stale c%0d: got v=%b i=%h want v=0",
                 c, out_valid, out_instr);
      end
    end
    set_in(5'd4, 5'd1, 5'd2, 5'd3, 32'h0, 26'h0);
    step();
    clear_in();
    total++;
    if (out_valid !== 1'b1 || out_instr !== 32'h00221825 ||
        out_last !== 1'b1) begin
      bad++;
      $display("FAIL mid_next: got v=%b i=%h l=%b want 1 00221825 1",
               out_valid, out_instr, out_last);
    end
    step();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_back_to_back();
    test_li_two();
    test_li_single();
    test_misc_ops();
    test_unknown();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
